// File: rtl/vliw_bundle_fetch_if.sv
// vliw_bundle_fetch_if: loader, fetch control and decode-side signals of vliw_bundle_fetch.
// Defining VLIW_FETCH_PERF_EN adds the perf_issued / perf_nop counter outputs.
interface vliw_bundle_fetch_if #(
    parameter int unsigned N_SLOTS = 10,
    parameter int unsigned SLOT_W  = 32,
    parameter int unsigned ADDR_W  = 6
);
    localparam int unsigned BW = N_SLOTS * SLOT_W;

    logic                ld_valid;
    logic                ld_ready;
    logic [ADDR_W-1:0]   ld_addr;
    logic [BW-1:0]       ld_bundle;
    logic                start;
    logic [ADDR_W-1:0]   start_pc;
    logic                stall;
    logic                branch_en;
    logic [ADDR_W-1:0]   branch_target;
    logic                f_valid;
    logic [ADDR_W-1:0]   f_pc;
    logic [BW-1:0]       f_bundle;
    logic [N_SLOTS-1:0]  f_slot_valid;
    logic                busy;
    logic                done;

`ifdef VLIW_FETCH_PERF_EN
    logic [31:0]         perf_issued;
    logic [31:0]         perf_nop;

    modport master (
        output ld_valid, ld_addr, ld_bundle, start, start_pc, stall, branch_en, branch_target,
        input  ld_ready, f_valid, f_pc, f_bundle, f_slot_valid, busy, done, perf_issued, perf_nop
    );
    modport slave (
        input  ld_valid, ld_addr, ld_bundle, start, start_pc, stall, branch_en, branch_target,
        output ld_ready, f_valid, f_pc, f_bundle, f_slot_valid, busy, done, perf_issued, perf_nop
    );
`else
    modport master (
        output ld_valid, ld_addr, ld_bundle, start, start_pc, stall, branch_en, branch_target,
        input  ld_ready, f_valid, f_pc, f_bundle, f_slot_valid, busy, done
    );
    modport slave (
        input  ld_valid, ld_addr, ld_bundle, start, start_pc, stall, branch_en, branch_target,
        output ld_ready, f_valid, f_pc, f_bundle, f_slot_valid, busy, done
    );
`endif
endinterface

// File: rtl/vliw_bundle_fetch.sv
// vliw_bundle_fetch: VLIW bundle store with sparse loading and a one-bundle-per-cycle fetch
// engine with stall and branch redirect. Unwritten entries read as all-zero NOP bundles.
// Optional feature macro: VLIW_FETCH_PERF_EN (issued / NOP bundle counters).
module vliw_bundle_fetch #(
    parameter int unsigned N_SLOTS = 10,
    parameter int unsigned SLOT_W  = 32,
    parameter int unsigned DEPTH   = 64,
    parameter int unsigned ADDR_W  = 6
) (
    input  logic               clk,
    input  logic               rst,
    vliw_bundle_fetch_if.slave bus
);
    localparam int unsigned BW    = N_SLOTS * SLOT_W;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_X  = (ADDR_W + 1)'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, FETCH, HALTED} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   pc;
    logic [ADDR_W-1:0]   f_pc;
    logic                f_valid;
    logic                done;
    logic [BW-1:0]       f_bundle;
    logic [BW-1:0]       mem [DEPTH];
    logic [DEPTH-1:0]    valid;

    logic                ld_ready;
    logic                ld_fire;
    logic                pc_in_range;
    logic                pc_last;
    logic                bt_in_range;
    logic [BW-1:0]       rd_data;
    logic [N_SLOTS-1:0]  slot_valid_c;

    // Loader and start are only accepted while the fetch engine is parked
    assign ld_ready    = (state != FETCH);
    assign ld_fire     = bus.ld_valid && ld_ready && ({1'b0, bus.ld_addr} < DEPTH_X);
    assign pc_in_range = ({1'b0, pc} < DEPTH_X);
    assign pc_last     = ({1'b0, pc} >= LAST_X);
    assign bt_in_range = ({1'b0, bus.branch_target} < DEPTH_X);
    assign rd_data     = (pc_in_range && valid[IDX_W'(pc)]) ? mem[IDX_W'(pc)] : '0;

    // Bundle storage; no reset, the valid bits decide what is visible
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem[IDX_W'(bus.ld_addr)] <= bus.ld_bundle;
        end
    end

    // Per-entry written flags; reset discards the loaded program
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid <= '0;
        end else if (ld_fire) begin
            valid[IDX_W'(bus.ld_addr)] <= 1'b1;
        end
    end

    // Fetch state machine with registered fetch outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= '0;
            f_valid  <= 1'b0;
            f_pc     <= '0;
            f_bundle <= '0;
            done     <= 1'b0;
        end else if (!bus.stall) begin
            unique case (state)
                IDLE, HALTED: begin
                    f_valid <= 1'b0;
                    if (bus.start) begin
                        state <= FETCH;
                        pc    <= bus.start_pc;
                        done  <= 1'b0;
                    end
                end
                FETCH: begin
                    if (bus.branch_en) begin
                        f_valid <= 1'b0;
                        if (bt_in_range) begin
                            pc <= bus.branch_target;
                        end else begin
                            state <= HALTED;
                            done  <= 1'b1;
                        end
                    end else begin
                        f_bundle <= rd_data;
                        f_pc     <= pc;
                        f_valid  <= 1'b1;
                        if (pc_last) begin
                            state <= HALTED;
                            done  <= 1'b1;
                        end else begin
                            pc <= pc + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Per-slot occupancy of the presented bundle
    always_comb begin
        slot_valid_c = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            slot_valid_c[i] = |f_bundle[i*SLOT_W +: SLOT_W];
        end
    end

    assign bus.ld_ready     = ld_ready;
    assign bus.f_valid      = f_valid;
    assign bus.f_pc         = f_pc;
    assign bus.f_bundle     = f_bundle;
    assign bus.f_slot_valid = slot_valid_c;
    assign bus.busy         = (state == FETCH);
    assign bus.done         = done;

`ifdef VLIW_FETCH_PERF_EN
    logic [31:0] perf_issued;
    logic [31:0] perf_nop;
    logic        deliver;
    logic        start_fire;

    assign deliver    = (state == FETCH) && !bus.stall && !bus.branch_en;
    assign start_fire = ld_ready && bus.start && !bus.stall;

    // Saturating delivered / NOP bundle counters, cleared by an accepted start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued <= '0;
            perf_nop    <= '0;
        end else if (start_fire) begin
            perf_issued <= '0;
            perf_nop    <= '0;
        end else if (deliver) begin
            if (perf_issued != '1) begin
                perf_issued <= perf_issued + 32'd1;
            end
            if ((rd_data == '0) && (perf_nop != '1)) begin
                perf_nop <= perf_nop + 32'd1;
            end
        end
    end

    assign bus.perf_issued = perf_issued;
    assign bus.perf_nop    = perf_nop;
`endif
endmodule

// File: tb/tb_vliw_bundle_fetch.sv
// tb_vliw_bundle_fetch: scoreboard bench for vliw_bundle_fetch. A 7-bit address is used so
// that out-of-range loads and branch targets (>= DEPTH) can be driven.
module tb_vliw_bundle_fetch;
    localparam int unsigned N_SLOTS = 10;
    localparam int unsigned SLOT_W  = 32;
    localparam int unsigned DEPTH   = 64;
    localparam int unsigned ADDR_W  = 7;
    localparam int unsigned BW      = N_SLOTS * SLOT_W;

    typedef logic [BW-1:0] bundle_t;
    typedef struct {
        int      pc;
        bundle_t bundle;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    vliw_bundle_fetch_if #(.N_SLOTS(N_SLOTS), .SLOT_W(SLOT_W), .ADDR_W(ADDR_W)) bus ();

    vliw_bundle_fetch #(.N_SLOTS(N_SLOTS), .SLOT_W(SLOT_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    bundle_t ref_mem   [DEPTH];
    logic    ref_valid [DEPTH];
    exp_t    sb [$];
    int      n_cmp = 0;
    int      n_bad = 0;

    task automatic chk(input string tag, input bundle_t obs, input bundle_t exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t mk(input logic [31:0] seed, input logic [N_SLOTS-1:0] mask);
        bundle_t b = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (mask[i]) b[i*SLOT_W +: SLOT_W] = (32'(i + 1) << 8) | seed;
        end
        return b;
    endfunction

    function automatic logic [N_SLOTS-1:0] slot_of(input bundle_t b);
        logic [N_SLOTS-1:0] r = '0;
        for (int i = 0; i < N_SLOTS; i++) r[i] = (b[i*SLOT_W +: SLOT_W] != '0);
        return r;
    endfunction

    function automatic bundle_t exp_of(input int pc);
        return ref_valid[pc] ? ref_mem[pc] : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input int addr, input bundle_t b);
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = ADDR_W'(addr);
        bus.ld_bundle = b;
        if (addr < DEPTH) begin
            ref_mem[addr]   = b;
            ref_valid[addr] = 1'b1;
        end
        tick();
        bus.ld_valid = 1'b0;
    endtask

    task automatic expect_run(input int first, input int last);
        exp_t e;
        for (int p = first; p <= last; p++) begin
            e.pc     = p;
            e.bundle = exp_of(p);
            sb.push_back(e);
        end
    endtask

    task automatic start_at(input int pc);
        bus.start    = 1'b1;
        bus.start_pc = ADDR_W'(pc);
        tick();
        bus.start = 1'b0;
    endtask

    // Advance one edge and score any bundle the DUT delivers
    task automatic fetch_cycle();
        exp_t e;
        tick();
        if (bus.f_valid) begin
            if (sb.size() == 0) begin
                chk("extra_f_valid", BW'(bus.f_valid), BW'(0));
            end else begin
                e = sb.pop_front();
                chk("f_pc", BW'(bus.f_pc), BW'(e.pc));
                chk("f_bundle", bus.f_bundle, e.bundle);
                chk("f_slot_valid", BW'(bus.f_slot_valid), BW'(slot_of(e.bundle)));
            end
        end
    endtask

    task automatic chk_parked(input string tag, input logic exp_done);
        chk({tag, "_busy"}, BW'(bus.busy), BW'(0));
        chk({tag, "_ld_ready"}, BW'(bus.ld_ready), BW'(1));
        chk({tag, "_done"}, BW'(bus.done), BW'(exp_done));
    endtask

    initial begin
        bundle_t bA;
        bundle_t bB;
        int      nops;

        bus.ld_valid      = 1'b0;
        bus.ld_addr       = '0;
        bus.ld_bundle     = '0;
        bus.start         = 1'b0;
        bus.start_pc      = '0;
        bus.stall         = 1'b0;
        bus.branch_en     = 1'b0;
        bus.branch_target = '0;
        for (int i = 0; i < DEPTH; i++) begin
            ref_valid[i] = 1'b0;
            ref_mem[i]   = '0;
        end

        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_f_valid", BW'(bus.f_valid), BW'(0));
        chk("rst_f_pc", BW'(bus.f_pc), BW'(0));
        chk("rst_f_bundle", bus.f_bundle, '0);
        chk("rst_slot_valid", BW'(bus.f_slot_valid), BW'(0));
        chk_parked("rst", 1'b0);

        bA = mk(32'h0000000A, '1);
        bB = mk(32'h0000000B, 10'h155);
        load(8, bB);
        load(26, mk(32'h0000000C, 10'h201));
        load(27, mk(32'h0000000D, 10'h020));
        load(60, mk(32'h0000000E, '1));
        load(62, mk(32'h0000000F, 10'h001));
        load(63, mk(32'h00000005, 10'h200));
        load(100, mk(32'h00000007, '1));

        // Run 1: load of entry 0 shares the start edge, then stall, branch, run to the end
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = '0;
        bus.ld_bundle = bA;
        ref_mem[0]    = bA;
        ref_valid[0]  = 1'b1;
        expect_run(0, 10);
        bus.start    = 1'b1;
        bus.start_pc = '0;
        tick();
        bus.start    = 1'b0;
        bus.ld_valid = 1'b0;
        chk("start_f_valid", BW'(bus.f_valid), BW'(0));
        chk("start_busy", BW'(bus.busy), BW'(1));
        chk("start_ld_ready", BW'(bus.ld_ready), BW'(0));
        fetch_cycle();
        chk("first_f_valid", BW'(bus.f_valid), BW'(1));
        repeat (4) fetch_cycle();

        bus.stall         = 1'b1;
        bus.branch_en     = 1'b1;
        bus.branch_target = ADDR_W'(50);
        bus.ld_valid      = 1'b1;
        bus.ld_addr       = ADDR_W'(5);
        bus.ld_bundle     = mk(32'h000000EE, '1);
        repeat (3) begin
            tick();
            chk("stall_f_valid", BW'(bus.f_valid), BW'(1));
            chk("stall_f_pc", BW'(bus.f_pc), BW'(4));
            chk("stall_f_bundle", bus.f_bundle, exp_of(4));
        end
        bus.stall     = 1'b0;
        bus.branch_en = 1'b0;
        fetch_cycle();
        bus.ld_valid = 1'b0;
        repeat (5) fetch_cycle();

        bus.branch_en     = 1'b1;
        bus.branch_target = ADDR_W'(26);
        expect_run(26, 63);
        tick();
        bus.branch_en = 1'b0;
        chk("branch_bubble", BW'(bus.f_valid), BW'(0));
        chk("branch_busy", BW'(bus.busy), BW'(1));
        repeat (38) fetch_cycle();
        chk("end_f_valid_held", BW'(bus.f_valid), BW'(1));
        chk_parked("end", 1'b1);
        tick();
        chk("end_f_valid_clear", BW'(bus.f_valid), BW'(0));
        chk("run1_drained", BW'(sb.size()), BW'(0));

        // Run 2: from 60 to the last entry
        expect_run(60, 63);
        start_at(60);
        chk("r2_done_clear", BW'(bus.done), BW'(0));
        chk("r2_f_valid", BW'(bus.f_valid), BW'(0));
        repeat (4) fetch_cycle();
        tick();
        chk("r2_f_valid_clear", BW'(bus.f_valid), BW'(0));
        chk_parked("r2", 1'b1);
`ifdef VLIW_FETCH_PERF_EN
        nops = 0;
        for (int p = 60; p < 64; p++) if (exp_of(p) == '0) nops++;
        chk("perf_issued", BW'(bus.perf_issued), BW'(4));
        chk("perf_nop", BW'(bus.perf_nop), BW'(nops));
`else
        nops = 0;
`endif

        // Run 3: branch beyond the store halts
        expect_run(0, 3);
        start_at(0);
        chk("r3_done_clear", BW'(bus.done), BW'(0));
        repeat (4) fetch_cycle();
        bus.branch_en     = 1'b1;
        bus.branch_target = ADDR_W'(70);
        tick();
        bus.branch_en = 1'b0;
        chk("far_branch_f_valid", BW'(bus.f_valid), BW'(0));
        chk_parked("far_branch", 1'b1);
        fetch_cycle();
        chk("r3_drained", BW'(sb.size()), BW'(nops * 0));

        // Run 4: asynchronous reset mid-run, then a run over the emptied store
        expect_run(0, 10);
        start_at(0);
        repeat (11) fetch_cycle();
        #2 rst = 1'b1;
        #1;
        chk("arst_f_valid", BW'(bus.f_valid), BW'(0));
        chk("arst_f_pc", BW'(bus.f_pc), BW'(0));
        chk("arst_f_bundle", bus.f_bundle, '0);
        chk_parked("arst", 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < DEPTH; i++) ref_valid[i] = 1'b0;
        chk("arst_idle_f_valid", BW'(bus.f_valid), BW'(0));

        expect_run(0, 63);
        start_at(0);
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = ADDR_W'(2);
        bus.ld_bundle = mk(32'h00000099, '1);
        repeat (2) fetch_cycle();
        bus.ld_valid = 1'b0;
        repeat (62) fetch_cycle();
        chk("r4_done", BW'(bus.done), BW'(1));
        chk("r4_drained", BW'(sb.size()), BW'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
